// File: rtl/dllp2tlp_if.sv
// -----------------------------------------------------------------------------
// dllp2tlp_if
// AXI-Stream bundle used on both sides of the dllp2tlp receive framer.
//
// Handshake: a beat transfers on a rising clock edge where tvalid and tready
// are both high. The source holds tdata/tkeep/tlast/tuser stable and keeps
// tvalid high until that edge; the sink may change tready at any time.
//
// Signals:
//   tdata  DATA_WIDTH  payload word
//   tkeep  KEEP_WIDTH  byte enables
//   tvalid 1           source has a beat
//   tlast  1           final beat of a packet
//   tuser  USER_WIDTH  sideband
//   tready 1           sink accepts
// Modports: master drives the beat and samples tready; slave is the reverse.
// -----------------------------------------------------------------------------
interface dllp2tlp_if #(
  parameter int DATA_WIDTH = 32,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8,
  parameter int USER_WIDTH = 3
);
  logic [DATA_WIDTH-1:0] tdata;
  logic [KEEP_WIDTH-1:0] tkeep;
  logic                  tvalid;
  logic                  tlast;
  logic [USER_WIDTH-1:0] tuser;
  logic                  tready;

  modport master (
    output tdata, tkeep, tvalid, tlast, tuser,
    input  tready
  );

  modport slave (
    input  tdata, tkeep, tvalid, tlast, tuser,
    output tready
  );
endinterface

// File: rtl/dllp2tlp.sv
// -----------------------------------------------------------------------------
// dllp2tlp
// Receive-side data link layer framer. Strips the sequence-number header and
// the LCRC from each DLL frame, checks the LCRC and the sequence number
// against NEXT_RCV_SEQ, forwards the TLP words with a discard flag on the last
// beat, and produces one ACK/NAK request per frame.
//
// Ports:
//   clk_i            clock, rising edge
//   rst_i            asynchronous active-high reset
//   s_axis_if        framed input stream (header, TLP words, LCRC on tlast)
//   m_axis_if        TLP output stream; tuser[0] = discard, valid with tlast
//   ack_nak_valid_o  ACK/NAK request pending
//   ack_nak_type_o   0 = ACK, 1 = NAK
//   ack_nak_seq_o    AckNak_Seq_Num
//   ack_nak_ready_i  request consumed
//   next_rcv_seq_o   current NEXT_RCV_SEQ
//   nak_scheduled_o  NAK_SCHEDULED flag
//   state_o          framer state (0 = HDR, 1 = BODY) for observation
// -----------------------------------------------------------------------------
module dllp2tlp #(
  parameter int DATA_WIDTH = 32,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8,
  parameter int USER_WIDTH = 3,
  parameter int SEQ_WIDTH  = 12
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  dllp2tlp_if.slave            s_axis_if,
  dllp2tlp_if.master           m_axis_if,
  output logic                 ack_nak_valid_o,
  output logic                 ack_nak_type_o,
  output logic [SEQ_WIDTH-1:0] ack_nak_seq_o,
  input  logic                 ack_nak_ready_i,
  output logic [SEQ_WIDTH-1:0] next_rcv_seq_o,
  output logic                 nak_scheduled_o,
  output logic                 state_o
);

  localparam logic [31:0]          CRC_POLY = 32'h04C1_1DB7;
  localparam logic [31:0]          CRC_INIT = 32'hFFFF_FFFF;
  localparam logic [SEQ_WIDTH-1:0] SEQ_ONE  = SEQ_WIDTH'(1);
  // Half the sequence space: distances 1..SEQ_HALF behind NEXT_RCV_SEQ are
  // duplicates, everything else that does not match is out of order.
  localparam logic [SEQ_WIDTH-1:0] SEQ_HALF = {1'b1, {(SEQ_WIDTH-1){1'b0}}};

  typedef enum logic {
    S_HDR  = 1'b0,
    S_BODY = 1'b1
  } state_t;

  // One 32-bit word folded into the CRC, MSB first, non-reflected.
  function automatic logic [31:0] crc32_word(input logic [31:0] crc_in,
                                             input logic [31:0] data);
    logic [31:0] c;
    c = crc_in;
    for (int i = 31; i >= 0; i--) begin
      if (c[31] ^ data[i]) c = (c << 1) ^ CRC_POLY;
      else                 c = c << 1;
    end
    return c;
  endfunction

  state_t                state_q, state_d;
  logic [31:0]           crc_q, crc_d;
  logic [SEQ_WIDTH-1:0]  seq_q, seq_d;
  logic                  hold_valid_q, hold_valid_d;
  logic [DATA_WIDTH-1:0] hold_data_q, hold_data_d;
  logic [KEEP_WIDTH-1:0] hold_keep_q, hold_keep_d;
  logic [USER_WIDTH-2:0] hold_user_q, hold_user_d;

  logic                  m_valid_q, m_valid_d;
  logic [DATA_WIDTH-1:0] m_data_q, m_data_d;
  logic [KEEP_WIDTH-1:0] m_keep_q, m_keep_d;
  logic                  m_last_q, m_last_d;
  logic [USER_WIDTH-1:0] m_user_q, m_user_d;

  logic                  an_valid_q, an_valid_d;
  logic                  an_type_q, an_type_d;
  logic [SEQ_WIDTH-1:0]  an_seq_q, an_seq_d;
  logic [SEQ_WIDTH-1:0]  next_q, next_d;
  logic                  nak_q, nak_d;

  logic                  s_ready;
  logic                  in_fire;
  logic [31:0]           crc_step;
  logic                  malformed;
  logic                  frame_bad;
  logic                  seq_match;
  logic                  seq_dup;
  logic [SEQ_WIDTH-1:0]  seq_diff;
  logic                  accept;

  // Bit 0 of the input sideband is replaced by the discard flag on output.
  logic                  unused_tuser_bit;
  assign unused_tuser_bit = s_axis_if.tuser[0];

  // No skid buffer: input is taken only when the output register is free or
  // draining this cycle.
  assign s_ready = !m_valid_q || m_axis_if.tready;
  assign in_fire = s_axis_if.tvalid && s_ready;

  // ---------------------------------------------------------------------------
  // State register (all sequential state)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= S_HDR;
      crc_q        <= CRC_INIT;
      seq_q        <= '0;
      hold_valid_q <= 1'b0;
      hold_data_q  <= '0;
      hold_keep_q  <= '0;
      hold_user_q  <= '0;
      m_valid_q    <= 1'b0;
      m_data_q     <= '0;
      m_keep_q     <= '0;
      m_last_q     <= 1'b0;
      m_user_q     <= '0;
      an_valid_q   <= 1'b0;
      an_type_q    <= 1'b0;
      an_seq_q     <= '0;
      next_q       <= '0;
      nak_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      crc_q        <= crc_d;
      seq_q        <= seq_d;
      hold_valid_q <= hold_valid_d;
      hold_data_q  <= hold_data_d;
      hold_keep_q  <= hold_keep_d;
      hold_user_q  <= hold_user_d;
      m_valid_q    <= m_valid_d;
      m_data_q     <= m_data_d;
      m_keep_q     <= m_keep_d;
      m_last_q     <= m_last_d;
      m_user_q     <= m_user_d;
      an_valid_q   <= an_valid_d;
      an_type_q    <= an_type_d;
      an_seq_q     <= an_seq_d;
      next_q       <= next_d;
      nak_q        <= nak_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    if (in_fire) begin
      if (state_q == S_HDR) state_d = s_axis_if.tlast ? S_HDR : S_BODY;
      else if (s_axis_if.tlast) state_d = S_HDR;
    end
  end

  // ---------------------------------------------------------------------------
  // Frame evaluation (only meaningful on an accepted tlast beat)
  // ---------------------------------------------------------------------------
  always_comb begin
    crc_step  = crc32_word((state_q == S_HDR) ? CRC_INIT : crc_q,
                           s_axis_if.tdata[31:0]);
    // A tlast in HDR, or in BODY with nothing held, means no TLP word.
    malformed = (state_q == S_HDR) || !hold_valid_q;
    frame_bad = malformed || (~crc_q != s_axis_if.tdata[31:0]);
    seq_match = (seq_q == next_q);
    seq_diff  = next_q - seq_q;
    seq_dup   = (seq_diff != '0) && (seq_diff <= SEQ_HALF);
    accept    = !frame_bad && seq_match;
  end

  // ---------------------------------------------------------------------------
  // Output / datapath logic
  // ---------------------------------------------------------------------------
  always_comb begin
    crc_d        = crc_q;
    seq_d        = seq_q;
    hold_valid_d = hold_valid_q;
    hold_data_d  = hold_data_q;
    hold_keep_d  = hold_keep_q;
    hold_user_d  = hold_user_q;
    m_valid_d    = m_valid_q;
    m_data_d     = m_data_q;
    m_keep_d     = m_keep_q;
    m_last_d     = m_last_q;
    m_user_d     = m_user_q;
    an_valid_d   = an_valid_q;
    an_type_d    = an_type_q;
    an_seq_d     = an_seq_q;
    next_d       = next_q;
    nak_d        = nak_q;

    if (m_valid_q && m_axis_if.tready) m_valid_d = 1'b0;
    if (an_valid_q && ack_nak_ready_i) an_valid_d = 1'b0;

    if (in_fire) begin
      if (state_q == S_HDR) begin
        if (!s_axis_if.tlast) begin
          seq_d = s_axis_if.tdata[SEQ_WIDTH-1:0];
          crc_d = crc_step;
        end
      end else if (!s_axis_if.tlast) begin
        // The word just arriving is not the LCRC, so the held word is TLP
        // data and can be released.
        crc_d = crc_step;
        if (hold_valid_q) begin
          m_valid_d = 1'b1;
          m_data_d  = hold_data_q;
          m_keep_d  = hold_keep_q;
          m_last_d  = 1'b0;
          m_user_d  = {hold_user_q, 1'b0};
        end
        hold_valid_d = 1'b1;
        hold_data_d  = s_axis_if.tdata;
        hold_keep_d  = s_axis_if.tkeep;
        hold_user_d  = s_axis_if.tuser[USER_WIDTH-1:1];
      end else begin
        if (hold_valid_q) begin
          m_valid_d = 1'b1;
          m_data_d  = hold_data_q;
          m_keep_d  = hold_keep_q;
          m_last_d  = 1'b1;
          m_user_d  = {hold_user_q, !accept};
        end
        hold_valid_d = 1'b0;
      end

      if (s_axis_if.tlast) begin
        crc_d = CRC_INIT;
        if (frame_bad || (!seq_match && !seq_dup)) begin
          // Only the first bad frame since the last good one asks for a NAK.
          if (!nak_q) begin
            an_valid_d = 1'b1;
            an_type_d  = 1'b1;
            an_seq_d   = next_q - SEQ_ONE;
            nak_d      = 1'b1;
          end
        end else if (seq_match) begin
          an_valid_d = 1'b1;
          an_type_d  = 1'b0;
          an_seq_d   = seq_q;
          next_d     = next_q + SEQ_ONE;
          nak_d      = 1'b0;
        end else begin
          an_valid_d = 1'b1;
          an_type_d  = 1'b0;
          an_seq_d   = next_q - SEQ_ONE;
        end
      end
    end
  end

  assign s_axis_if.tready = s_ready;
  assign m_axis_if.tvalid = m_valid_q;
  assign m_axis_if.tdata  = m_data_q;
  assign m_axis_if.tkeep  = m_keep_q;
  assign m_axis_if.tlast  = m_last_q;
  assign m_axis_if.tuser  = m_user_q;

  assign ack_nak_valid_o  = an_valid_q;
  assign ack_nak_type_o   = an_type_q;
  assign ack_nak_seq_o    = an_seq_q;
  assign next_rcv_seq_o   = next_q;
  assign nak_scheduled_o  = nak_q;
  assign state_o          = state_q;

endmodule

// File: tb/tb_dllp2tlp.sv
// -----------------------------------------------------------------------------
// tb_dllp2tlp
// Directed frames into dllp2tlp; expected TLP beats and ACK/NAK requests are
// queued when each frame is issued and popped by independent monitors.
// -----------------------------------------------------------------------------
module tb_dllp2tlp;
  localparam int DW = 32;
  localparam int KW = 4;
  localparam int UW = 3;
  localparam int SW = 12;

  // ---------------------------------------------------------------- clock/reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dllp2tlp_if #(.DATA_WIDTH(DW), .KEEP_WIDTH(KW), .USER_WIDTH(UW)) s_if ();
  dllp2tlp_if #(.DATA_WIDTH(DW), .KEEP_WIDTH(KW), .USER_WIDTH(UW)) m_if ();

  logic          an_valid;
  logic          an_type;
  logic [SW-1:0] an_seq;
  logic          an_ready;
  logic [SW-1:0] next_seq;
  logic          nak_sched;
  logic          state_dbg;

  dllp2tlp #(.DATA_WIDTH(DW), .KEEP_WIDTH(KW), .USER_WIDTH(UW), .SEQ_WIDTH(SW)) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .s_axis_if       (s_if),
    .m_axis_if       (m_if),
    .ack_nak_valid_o (an_valid),
    .ack_nak_type_o  (an_type),
    .ack_nak_seq_o   (an_seq),
    .ack_nak_ready_i (an_ready),
    .next_rcv_seq_o  (next_seq),
    .nak_scheduled_o (nak_sched),
    .state_o         (state_dbg)
  );

  // ---------------------------------------------------------------- scoreboard
  int checks = 0;
  int errors = 0;
  // {tdata, tkeep, tlast, tuser}
  logic [39:0] out_exp_q[$];
  // {type, seq}
  logic [12:0] ack_exp_q[$];

  logic [SW-1:0] model_next = '0;
  logic          model_nak  = 1'b0;
  logic          ack_auto   = 1'b1;
  logic [12:0]   pending_req = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] crc_word(input logic [31:0] c_in, input logic [31:0] d);
    logic [31:0] c;
    c = c_in;
    for (int i = 31; i >= 0; i--) begin
      if (c[31] ^ d[i]) c = (c << 1) ^ 32'h04C1_1DB7;
      else              c = c << 1;
    end
    return c;
  endfunction

  function automatic logic [31:0] word_of(input logic [SW-1:0] seq, input int i);
    return {4'hC, seq, 16'(i * 16'h1111 + 1)};
  endfunction

  // Output monitor: a beat transfers at the next rising edge.
  always @(negedge clk) begin
    logic [39:0] e;
    if (!rst && m_if.tvalid && m_if.tready) begin
      if (out_exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL out_unexpected: got %0h expected no beat",
                 {m_if.tdata, m_if.tkeep, m_if.tlast, m_if.tuser});
      end else begin
        e = out_exp_q.pop_front();
        check("out_beat", 64'({m_if.tdata, m_if.tkeep, m_if.tlast, m_if.tuser}), 64'(e));
      end
    end
  end

  // ACK/NAK monitor.
  always @(negedge clk) begin
    logic [12:0] e;
    if (!rst && an_valid && an_ready) begin
      if (ack_exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL acknak_unexpected: got %0h expected no request", {an_type, an_seq});
      end else begin
        e = ack_exp_q.pop_front();
        check("acknak", 64'({an_type, an_seq}), 64'(e));
      end
    end
  end

  // ---------------------------------------------------------------- drivers
  task automatic put(input logic [31:0] d, input logic [3:0] k, input logic last,
                     input logic [2:0] u);
    int n;
    s_if.tdata  = d;
    s_if.tkeep  = k;
    s_if.tlast  = last;
    s_if.tuser  = u;
    s_if.tvalid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!s_if.tready && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (!s_if.tready) begin
      checks++;
      errors++;
      $display("FAIL put_timeout: got tready 0 expected 1 within 200 cycles");
    end
    @(posedge clk);
    #1;
  endtask

  // n = number of TLP words; n = 0 gives a 2-beat (malformed) frame.
  task automatic send_frame(input logic [SW-1:0] seq, input int n, input logic corrupt);
    logic [31:0]   c;
    logic [31:0]   hdr;
    logic [31:0]   lcrc;
    logic [SW-1:0] diff;
    logic          acc;
    logic          dup;
    logic          req;
    logic [12:0]   r;
    logic          last;
    logic [3:0]    k;
    hdr = {20'hABCDE, seq};
    c = crc_word(32'hFFFF_FFFF, hdr);
    for (int i = 0; i < n; i++) c = crc_word(c, word_of(seq, i));
    lcrc = ~c ^ {31'd0, corrupt};

    diff = model_next - seq;
    acc  = (n > 0) && !corrupt && (seq == model_next);
    dup  = (n > 0) && !corrupt && !acc && (diff != 12'd0) && (diff <= 12'h800);
    req  = 1'b0;
    r    = '0;
    if (acc) begin
      req = 1'b1; r = {1'b0, seq};
      model_next = model_next + 12'd1;
      model_nak  = 1'b0;
    end else if (dup) begin
      req = 1'b1; r = {1'b0, model_next - 12'd1};
    end else if (!model_nak) begin
      req = 1'b1; r = {1'b1, model_next - 12'd1};
      model_nak = 1'b1;
    end
    if (req) begin
      if (ack_auto) ack_exp_q.push_back(r);
      else          pending_req = r;
    end

    for (int i = 0; i < n; i++) begin
      last = (i == n - 1);
      k    = last ? 4'h7 : 4'hF;
      out_exp_q.push_back({word_of(seq, i), k, last, 2'(i + 1), last & !acc});
    end

    put(hdr, 4'hF, 1'b0, 3'b001);
    for (int i = 0; i < n; i++)
      put(word_of(seq, i), (i == n - 1) ? 4'h7 : 4'hF, 1'b0, {2'(i + 1), 1'b1});
    put(lcrc, 4'h0, 1'b1, 3'b111);
    s_if.tvalid = 1'b0;
  endtask

  // ---------------------------------------------------------------- watchdog
  initial begin
    #900000;
    $display("FAIL watchdog: got no finish expected finish before 900us");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------- stimulus
  initial begin
    s_if.tvalid = 1'b0;
    s_if.tdata  = '0;
    s_if.tkeep  = '0;
    s_if.tlast  = 1'b0;
    s_if.tuser  = '0;
    m_if.tready = 1'b1;
    an_ready    = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    check("rst_m_tvalid",   64'(m_if.tvalid), 64'(0));
    check("rst_acknak_vld", 64'(an_valid),    64'(0));
    check("rst_next_seq",   64'(next_seq),    64'(0));
    check("rst_nak_sched",  64'(nak_sched),   64'(0));
    check("rst_s_tready",   64'(s_if.tready), 64'(1));
    check("rst_state",      64'(state_dbg),   64'(0));
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Bad LCRC twice: one NAK 0xFFF, then silence.
    send_frame(12'h000, 3, 1'b1);
    check("bad1_nak_sched", 64'(nak_sched), 64'(1));
    send_frame(12'h000, 3, 1'b1);
    check("bad2_nak_sched", 64'(nak_sched), 64'(1));
    check("bad2_next_seq",  64'(next_seq),  64'(0));

    // Good frame seq 0 (A,B,C).
    send_frame(12'h000, 3, 1'b0);
    check("good0_next_seq",  64'(next_seq),  64'(1));
    check("good0_nak_sched", 64'(nak_sched), 64'(0));

    // Seq 1..4 back to back, then duplicate seq 3.
    for (int s = 1; s <= 4; s++) send_frame(12'(s), 2, 1'b0);
    send_frame(12'h003, 2, 1'b0);
    check("dup_next_seq", 64'(next_seq), 64'(5));

    // Out of order seq 7 -> NAK 4; malformed while NAK scheduled -> nothing.
    send_frame(12'h007, 1, 1'b0);
    check("ooo_nak_sched", 64'(nak_sched), 64'(1));
    send_frame(12'h005, 0, 1'b0);
    send_frame(12'h005, 1, 1'b0);
    check("good5_next_seq", 64'(next_seq), 64'(6));
    // Malformed with NAK clear -> NAK 5.
    send_frame(12'h006, 0, 1'b0);
    check("short_nak_sched", 64'(nak_sched), 64'(1));

    // Output stall for 5 cycles mid-frame.
    fork
      send_frame(12'h006, 4, 1'b0);
      begin
        repeat (3) @(posedge clk);
        #1;
        m_if.tready = 1'b0;
        for (int k = 0; k < 5; k++) begin
          @(negedge clk);
          check("stall_s_tready", 64'(s_if.tready), 64'(0));
          check("stall_m_tvalid", 64'(m_if.tvalid), 64'(1));
          check("stall_m_tdata",  64'(m_if.tdata),  64'(word_of(12'h006, 0)));
        end
        @(posedge clk);
        #1;
        m_if.tready = 1'b1;
      end
    join
    check("stall_next_seq", 64'(next_seq), 64'(7));

    // Walk NEXT_RCV_SEQ up to 0xFFF, then wrap.
    for (int s = 7; s <= 12'hFFE; s++) send_frame(12'(s), 1, 1'b0);
    check("pre_wrap_next_seq", 64'(next_seq), 64'(12'hFFF));
    send_frame(12'hFFF, 2, 1'b0);
    check("wrap_next_seq", 64'(next_seq), 64'(0));

    // Two ACKs not consumed: newest wins.
    repeat (3) @(posedge clk);
    #1;
    an_ready = 1'b0;
    ack_auto = 1'b0;
    send_frame(12'h000, 1, 1'b0);
    send_frame(12'h001, 1, 1'b0);
    @(negedge clk);
    check("hold_acknak_vld",  64'(an_valid), 64'(1));
    check("hold_acknak_type", 64'(an_type),  64'(0));
    check("hold_acknak_seq",  64'(an_seq),   64'(1));
    @(posedge clk);
    #1;
    ack_exp_q.push_back(pending_req);
    ack_auto = 1'b1;
    an_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    // Asynchronous reset in the middle of BODY with a beat parked on output.
    m_if.tready = 1'b0;
    put({20'hABCDE, 12'h002}, 4'hF, 1'b0, 3'b001);
    put(32'h1111_2222, 4'hF, 1'b0, 3'b011);
    put(32'h3333_4444, 4'hF, 1'b0, 3'b101);
    s_if.tvalid = 1'b0;
    #3;
    rst = 1'b1;
    #1;
    check("arst_m_tvalid",  64'(m_if.tvalid), 64'(0));
    check("arst_m_tdata",   64'(m_if.tdata),  64'(0));
    check("arst_m_tuser",   64'(m_if.tuser),  64'(0));
    check("arst_acknak",    64'({an_valid, an_type, an_seq}), 64'(0));
    check("arst_next_seq",  64'(next_seq),    64'(0));
    check("arst_nak_sched", 64'(nak_sched),   64'(0));
    check("arst_state",     64'(state_dbg),   64'(0));
    model_next = '0;
    model_nak  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    m_if.tready = 1'b1;
    send_frame(12'h000, 2, 1'b0);
    check("post_rst_next_seq", 64'(next_seq), 64'(1));

    // Drain.
    for (int i = 0; i < 50 && (out_exp_q.size() != 0 || ack_exp_q.size() != 0); i++)
      @(posedge clk);
    #1;
    check("out_queue_empty", 64'(out_exp_q.size()), 64'(0));
    check("ack_queue_empty", 64'(ack_exp_q.size()), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
